// File: rtl/seq_divider.sv
// seq_divider: signed 32-bit restoring divider, one quotient bit per clock.
// Result packs {remainder, quotient}; the remainder takes the dividend's sign.
module subtractor (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] diff
);
  assign diff = a - b;
endmodule

module seq_divider (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [63:0] Result
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] q_q, q_d, r_q, r_d, d_q, d_d;
  logic        sa_q, sa_d, sq_q, sq_d, dz_q, dz_d;
  logic        busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [63:0] res_q, res_d;
  logic [31:0] rs;
  logic [63:0] t;
  assign rs = {r_q[30:0], q_q[31]};
  subtractor u_sub (.a({32'h0, rs}), .b({32'h0, d_q}), .diff(t));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    sa_d    = sa_q;
    sq_d    = sq_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (start) begin
        cnt_d = 6'd0;
        d_d   = B[31] ? -B : B;
        // a zero divisor parks A in R so FIX emits {A, all-ones} unchanged
        if (B == 32'h0) begin
          r_d     = A;
          q_d     = 32'hFFFF_FFFF;
          sa_d    = 1'b0;
          sq_d    = 1'b0;
          dz_d    = 1'b1;
          state_d = FIX;
        end else begin
          r_d     = 32'h0;
          q_d     = A[31] ? -A : A;
          sa_d    = A[31];
          sq_d    = A[31] ^ B[31];
          dz_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        r_d     = t[63] ? rs : t[31:0];
        q_d     = {q_q[30:0], ~t[63]};
        cnt_d   = cnt_q + 6'd1;
        state_d = (cnt_q == 6'd31) ? FIX : RUN;
      end
      FIX: begin
        res_d   = {sa_q ? -r_q : r_q, sq_q ? -q_q : q_q};
        dbz_d   = dz_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = 6'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      q_q     <= 32'h0;
      r_q     <= 32'h0;
      d_q     <= 32'h0;
      sa_q    <= 1'b0;
      sq_q    <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      res_q   <= 64'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      sa_q    <= sa_d;
      sq_q    <= sq_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      res_q   <= res_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign Result      = res_q;
endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle signed 32-bit divider for the datapath ALU. It completes the inverse of the multiply path: restoring division, one quotient bit per clock. Each iteration's trial subtraction uses the team's 64-bit `subtractor`. The 64-bit result is packed as {remainder, quotient}, which the ALU routes to the HI and LO registers.

## Interface
- No parameters; width is fixed at 32-bit operands and a 64-bit result.
- clock  input  1  rising-edge clock for all state.
- clear  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request; sampled only when idle.
- A  input  32  dividend, two's complement; captured on the accepted start edge.
- B  input  32  divisor, two's complement; captured on the accepted start edge.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when Result is valid.
- div_by_zero  output  1  set with done when B was 0; held until next completion.
- Result  output  64  [63:32] remainder, [31:0] quotient; held until next completion.

## Operation
- States:
  - IDLE.
  - RUN, with a 6-bit iteration counter 0..31.
  - FIX, the sign correction and result load.
- IDLE:
  - start=1 captures A and B.
  - Stores sign flags sA = A[31] and sQ = A[31]^B[31].
  - Loads Q = |A|, R = 0, D = |B|.
  - |x| is two's-complement negation when x[31]=1. |0x80000000| = 0x80000000 as unsigned.
  - If B == 0, the block does not enter RUN. It goes directly to the done cycle with Result = {A, 32'hFFFFFFFF} and div_by_zero=1.
  - Otherwise it goes to RUN with counter = 0.
- RUN, one iteration per clock:
  - Shift {R, Q} left by 1.
  - Compute T = R_shifted − D with `subtractor` on zero-extended 32-bit operands; the borrow is T[63].
  - Borrow=0: R = T[31:0], Q[0] = 1.
  - Borrow=1: R unchanged (restore), Q[0] = 0.
  - R < D ≤ 2^31 always holds, so R fits in 32 bits.
  - Counter increments. After iteration 31, go to FIX.
- FIX:
  - Quotient = sQ ? −Q : Q.
  - Remainder = sA ? −R : R, so the remainder takes the dividend's sign.
  - Load Result. done=1 and div_by_zero=0 for this cycle. Return to IDLE.
- Overflow case 0x80000000 / 0xFFFFFFFF:
  - Quotient = 0x80000000 (natural wrap), remainder = 0. No flag is raised.
- start while busy is ignored; captured operands are not disturbed.

## Timing
- Let E0 be the rising edge at which start is accepted.
- Normal division:
  - Edges E1..E32 perform the 32 iterations. E33 performs FIX.
  - busy is high from E0 until E33, falling at E33.
  - done is high from E33 until E34, one cycle, coincident with the new Result.
  - Latency from the start edge to Result valid is 33 clocks.
- Divide by zero:
  - busy stays 0.
  - done, div_by_zero and Result update at E0 + 1.
  - Latency is 1 clock.
- start may be asserted in the done cycle and is accepted at the following edge, giving back-to-back operations with no dead cycle.
- clear=0, asynchronously at any time including mid-RUN:
  - State goes to IDLE and the counter to 0.
  - busy=0, done=0, div_by_zero=0, Result=64'h0.
  - The in-flight operation is discarded.
- Reset values of every output are 0.
- Result and div_by_zero change only in the done cycle.

## Test plan
- A=100, B=7, start pulse: at E33, Result = {32'd2, 32'd14}; done pulses exactly one cycle; busy is high for 33 cycles.
- A=−100 (0xFFFFFF9C), B=7: Result = {32'hFFFFFFFE, 32'hFFFFFFF2}. A=100, B=−7: Result = {32'd2, 32'hFFFFFFF2}.
- A=7, B=0: at E0+1, done=1, div_by_zero=1, Result = {32'd7, 32'hFFFFFFFF}; busy never rises.
- Boundary operands:
  - A=0x80000000, B=0xFFFFFFFF: Result = {32'h0, 32'h80000000}.
  - A=0x7FFFFFFF, B=1: Result = {32'h0, 32'h7FFFFFFF}.
  - A=0, B=5: Result = 64'h0.
- Handshake and reset:
  - start re-pulsed mid-RUN with different A and B: ignored, and the first result is correct.
  - clear pulsed low at iteration 10: all outputs read 0 immediately. A new start of 100/7 then completes correctly 33 clocks later.
